// File: rtl/riscv_isa_pkg.sv
// riscv_isa_pkg
// Shared definitions for the machine-mode trap unit and its neighbours:
//   - CSR addresses owned by the trap unit
//   - decoder CSR control bundle (ctl_csr_t)
//   - exception / interrupt cause codes
//   - mtvec mode encoding
//   - trap FSM state type
//   - helper computing the value a CSR instruction writes
package riscv_isa_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Bit positions of the two implemented mstatus fields
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Only MSI/MTI/MEI exist in mie/mip
  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

  typedef enum logic [1:0] {
    CSR_NON = 2'b00,
    CSR_RW  = 2'b01,
    CSR_SET = 2'b10,
    CSR_CLR = 2'b11
  } csr_op_t;

  typedef enum logic {
    CSR_REG = 1'b0,
    CSR_IMM = 1'b1
  } csr_msk_t;

  typedef struct packed {
    csr_op_t     op;
    csr_msk_t    msk;
    logic [11:0] adr;
    logic [4:0]  imm;
  } ctl_csr_t;

  typedef enum logic [3:0] {
    EXC_IADR_MISALIGN = 4'd0,
    EXC_IACCESS       = 4'd1,
    EXC_ILLEGAL       = 4'd2,
    EXC_BREAKPOINT    = 4'd3,
    EXC_LADR_MISALIGN = 4'd4,
    EXC_LACCESS       = 4'd5,
    EXC_SADR_MISALIGN = 4'd6,
    EXC_SACCESS       = 4'd7,
    EXC_ECALL_M       = 4'd11
  } exc_code_t;

  typedef enum logic [3:0] {
    IRQ_MSI = 4'd3,
    IRQ_MTI = 4'd7,
    IRQ_MEI = 4'd11
  } irq_code_t;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_t;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } trap_state_t;

  // Value written by a CSR instruction given the current register value.
  function automatic logic [31:0] csr_wval(
    input csr_op_t     op,
    input logic [31:0] old,
    input logic [31:0] wdt,
    input logic [31:0] msk
  );
    case (op)
      CSR_RW:  csr_wval = wdt;
      CSR_SET: csr_wval = old | msk;
      CSR_CLR: csr_wval = old & ~msk;
      default: csr_wval = old;
    endcase
  endfunction

endpackage

// File: rtl/r5p_trap_cnt.sv
// r5p_trap_cnt
// 64-bit free-running counter with independent write ports per 32-bit half.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   inc       - add one this cycle
//   wlo, whi  - replace the low / high half with wdt this cycle
//   wdt       - write data
//   cnt       - current 64-bit count
// A write to a half beats the increment of that half, but the carry out of
// the old low half still reaches the high half when only the low half is
// written.
module r5p_trap_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wlo,
  input  logic        whi,
  input  logic [31:0] wdt,
  output logic [63:0] cnt
);

  logic [63:0] sum;

  assign sum = cnt + {63'd0, inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt[31:0]  <= wlo ? wdt : sum[31:0];
      cnt[63:32] <= whi ? wdt : sum[63:32];
    end
  end

endmodule

// File: rtl/r5p_trap.sv
// r5p_trap
// Machine-mode trap unit. Owns mstatus (MIE/MPIE), mie, mip, mtvec, mepc,
// mcause, mtval, mscratch and the mcycle/minstret counters, arbitrates
// exceptions, interrupts and MRET, and requests a fetch redirect.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   ctl, wdt            - decoded CSR access and its write data
//   rdt, hit            - read data / address-owned flag for the core read mux
//   exc_*               - synchronous exception from the current instruction
//   mret, ret, nxt_pc   - MRET, retire strobe, interrupt return PC
//   irq_msi/mti/mei     - machine interrupt lines
//   red_vld/pc/rdy      - redirect handshake toward fetch
//   stall               - hold the core while a redirect is outstanding
module r5p_trap
  import riscv_isa_pkg::*;
#(
  parameter int unsigned XW        = 32,
  parameter logic [31:0] RST_MTVEC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  ctl_csr_t      ctl,
  input  logic [XW-1:0] wdt,
  output logic [XW-1:0] rdt,
  output logic          hit,
  input  logic          exc_vld,
  input  logic [3:0]    exc_cause,
  input  logic [XW-1:0] exc_pc,
  input  logic [XW-1:0] exc_tval,
  input  logic          mret,
  input  logic          ret,
  input  logic [XW-1:0] nxt_pc,
  input  logic          irq_msi,
  input  logic          irq_mti,
  input  logic          irq_mei,
  output logic          red_vld,
  output logic [XW-1:0] red_pc,
  input  logic          red_rdy,
  output logic          stall
);

  trap_state_t state, state_nxt;

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
  logic [31:0] red_pc_q, red_pc_nxt;
  logic [63:0] mcycle, minstret;

  logic [31:0] mstatus_v, mip_v, pend, mtvec_base, msk_v, wval;
  logic        irq_any, exc_take, irq_take, mret_take, evt, wen;
  irq_code_t   irq_code;

  assign mstatus_v  = {24'd0, mst_mpie, 3'd0, mst_mie, 3'd0};
  assign mip_v      = {20'd0, irq_mei, 3'd0, irq_mti, 3'd0, irq_msi, 3'd0};
  assign pend       = mip_v & mie_q;
  assign irq_any    = |pend;
  assign mtvec_base = {mtvec_q[31:2], 2'b00};

  // Event arbitration: exception beats interrupt beats MRET, and nothing is
  // accepted while a redirect is still outstanding.
  assign exc_take  = (state == RUN) && exc_vld;
  assign irq_take  = (state == RUN) && !exc_vld && mst_mie && irq_any;
  assign mret_take = (state == RUN) && !exc_vld && !irq_take && mret;
  assign evt       = exc_take || irq_take || mret_take;

  // Fixed interrupt priority MEI > MSI > MTI
  always_comb begin
    irq_code = IRQ_MTI;
    if (pend[11])     irq_code = IRQ_MEI;
    else if (pend[3]) irq_code = IRQ_MSI;
  end

  // Combinational read port for every trap-owned address
  always_comb begin
    rdt = '0;
    hit = 1'b1;
    case (ctl.adr)
      CSR_MSTATUS:   rdt = mstatus_v;
      CSR_MIE:       rdt = mie_q;
      CSR_MTVEC:     rdt = mtvec_q;
      CSR_MSCRATCH:  rdt = mscratch_q;
      CSR_MEPC:      rdt = mepc_q;
      CSR_MCAUSE:    rdt = mcause_q;
      CSR_MTVAL:     rdt = mtval_q;
      CSR_MIP:       rdt = mip_v;
      CSR_MCYCLE:    rdt = mcycle[31:0];
      CSR_MCYCLEH:   rdt = mcycle[63:32];
      CSR_MINSTRET:  rdt = minstret[31:0];
      CSR_MINSTRETH: rdt = minstret[63:32];
      default:       hit = 1'b0;
    endcase
  end

  // Write value uses the same read path as the old value, so set/clear work
  // on what software would observe. Writes are dropped on a trap event.
  assign msk_v = (ctl.msk == CSR_IMM) ? {27'd0, ctl.imm} : wdt;
  assign wval  = csr_wval(ctl.op, rdt, wdt, msk_v);
  assign wen   = (ctl.op != CSR_NON) && hit && !evt;

  // Redirect target chosen at the moment the event is accepted
  always_comb begin
    red_pc_nxt = red_pc_q;
    if (exc_take) begin
      red_pc_nxt = mtvec_base;
    end else if (irq_take) begin
      if (mtvec_q[1:0] == MTVEC_VECTORED)
        red_pc_nxt = mtvec_base + {26'd0, irq_code, 2'b00};
      else
        red_pc_nxt = mtvec_base;
    end else if (mret_take) begin
      red_pc_nxt = mepc_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt = state;
    red_vld   = 1'b0;
    case (state)
      RUN: begin
        if (evt) state_nxt = REDIR;
      end
      REDIR: begin
        red_vld = 1'b1;
        if (red_rdy) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign stall  = red_vld;
  assign red_pc = red_pc_q;

  // Trap CSR updates: trap entry/return first, software writes otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RST_MTVEC;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      red_pc_q   <= '0;
    end else begin
      red_pc_q <= red_pc_nxt;
      if (exc_take) begin
        mepc_q   <= exc_pc & ~32'h3;
        mcause_q <= {28'd0, exc_cause};
        mtval_q  <= exc_tval;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (irq_take) begin
        mepc_q   <= nxt_pc & ~32'h3;
        mcause_q <= {1'b1, 27'd0, irq_code};
        mtval_q  <= '0;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_take) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wen) begin
        case (ctl.adr)
          CSR_MSTATUS: begin
            mst_mie  <= wval[MSTATUS_MIE];
            mst_mpie <= wval[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= wval & IRQ_MASK;
          CSR_MTVEC:    mtvec_q    <= {wval[31:2],
                                       (wval[1:0] == MTVEC_VECTORED) ? 2'b01 : 2'b00};
          CSR_MSCRATCH: mscratch_q <= wval;
          CSR_MEPC:     mepc_q     <= wval & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= wval;
          CSR_MTVAL:    mtval_q    <= wval;
          default: ;
        endcase
      end
    end
  end

  r5p_trap_cnt u_mcycle (
    .clk (clk),
    .rst (rst),
    .inc (1'b1),
    .wlo (wen && (ctl.adr == CSR_MCYCLE)),
    .whi (wen && (ctl.adr == CSR_MCYCLEH)),
    .wdt (wval),
    .cnt (mcycle)
  );

  r5p_trap_cnt u_minstret (
    .clk (clk),
    .rst (rst),
    .inc (ret),
    .wlo (wen && (ctl.adr == CSR_MINSTRET)),
    .whi (wen && (ctl.adr == CSR_MINSTRETH)),
    .wdt (wval),
    .cnt (minstret)
  );

endmodule

// File: tb/tb_r5p_trap.sv
// tb_r5p_trap
// Directed bench for r5p_trap: reset state, exception entry, vectored
// interrupt, MRET, simultaneous-event priority, CSR write masking and
// counter rollover. Inputs change just after the falling edge.
module tb_r5p_trap;
  import riscv_isa_pkg::*;

  localparam logic [31:0] RSTV = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  ctl_csr_t    ctl;
  logic [31:0] wdt, rdt, exc_pc, exc_tval, nxt_pc, red_pc;
  logic [3:0]  exc_cause;
  logic        hit, exc_vld, mret, ret, irq_msi, irq_mti, irq_mei;
  logic        red_vld, red_rdy, stall;

  int errors = 0;
  int checks = 0;
  logic [31:0] d;

  r5p_trap #(.XW(32), .RST_MTVEC(RSTV)) dut (
    .clk(clk), .rst(rst), .ctl(ctl), .wdt(wdt), .rdt(rdt), .hit(hit),
    .exc_vld(exc_vld), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .ret(ret), .nxt_pc(nxt_pc),
    .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei),
    .red_vld(red_vld), .red_pc(red_pc), .red_rdy(red_rdy), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic csrWrite(input csr_op_t op, input logic [11:0] adr, input logic [31:0] val);
    ctl.op  = op;
    ctl.msk = CSR_REG;
    ctl.adr = adr;
    wdt     = val;
    tick();
    ctl.op  = CSR_NON;
  endtask

  task automatic csrRead(input logic [11:0] adr, output logic [31:0] v);
    ctl.op  = CSR_NON;
    ctl.adr = adr;
    #1;
    v = rdt;
  endtask

  task automatic acceptRedirect();
    red_rdy = 1'b1;
    tick();
    red_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    csrRead(CSR_MTVEC, d);
    checks++; if (d !== RSTV) begin errors++; $display("[TB] FAIL rst_mtvec: got %h expected %h", d, RSTV); end
    csrRead(CSR_MCYCLE, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL rst_mcycle: got %h expected %h", d, 32'd0); end
    checks++; if (red_vld !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_redir: got vld=%b stall=%b expected 0 0", red_vld, stall); end
    for (int i = 0; i < 10; i++) tick();
    csrRead(CSR_MCYCLE, d);
    checks++; if (d !== 32'd10) begin errors++; $display("[TB] FAIL mcycle_10: got %h expected %h", d, 32'd10); end
    csrRead(CSR_MSTATUS, d);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL rst_mstatus: got %h expected %h", d, 32'd0); end
    checks++; if (red_vld !== 1'b0) begin errors++; $display("[TB] FAIL rst_vld10: got %b expected 0", red_vld); end
  endtask

  task automatic test_exception();
    csrWrite(CSR_RW, CSR_MTVEC, 32'h100);
    csrWrite(CSR_RW, CSR_MSTATUS, 32'h8);
    exc_vld = 1'b1; exc_cause = 4'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
    tick();
    exc_vld = 1'b0;
    checks++; if (red_vld !== 1'b1 || red_pc !== 32'h100) begin errors++; $display("[TB] FAIL exc_redir: got vld=%b pc=%h expected 1 00000100", red_vld, red_pc); end
    csrRead(CSR_MEPC, d);
    checks++; if (d !== 32'h40) begin errors++; $display("[TB] FAIL exc_mepc: got %h expected %h", d, 32'h40); end
    csrRead(CSR_MCAUSE, d);
    checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL exc_mcause: got %h expected %h", d, 32'h2); end
    csrRead(CSR_MTVAL, d);
    checks++; if (d !== 32'hDEAD) begin errors++; $display("[TB] FAIL exc_mtval: got %h expected %h", d, 32'hDEAD); end
    csrRead(CSR_MSTATUS, d);
    checks++; if (d !== 32'h80) begin errors++; $display("[TB] FAIL exc_mstatus: got %h expected %h", d, 32'h80); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (red_vld !== 1'b1 || stall !== 1'b1 || red_pc !== 32'h100) begin
        errors++;
        $display("[TB] FAIL exc_hold%0d: got vld=%b stall=%b pc=%h expected 1 1 00000100", i, red_vld, stall, red_pc);
      end
    end
    acceptRedirect();
    checks++; if (red_vld !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL exc_release: got vld=%b stall=%b expected 0 0", red_vld, stall); end
  endtask

  task automatic test_vectored_irq();
    csrWrite(CSR_RW, CSR_MTVEC, 32'h201);
    csrWrite(CSR_RW, CSR_MIE, 32'h80);
    csrWrite(CSR_RW, CSR_MSTATUS, 32'h8);
    checks++; if (red_vld !== 1'b0) begin errors++; $display("[TB] FAIL irq_idle: got %b expected 0", red_vld); end
    irq_mti = 1'b1; nxt_pc = 32'h88;
    tick();
    irq_mti = 1'b0;
    checks++; if (red_vld !== 1'b1 || red_pc !== 32'h21C) begin errors++; $display("[TB] FAIL irq_redir: got vld=%b pc=%h expected 1 0000021c", red_vld, red_pc); end
    csrRead(CSR_MCAUSE, d);
    checks++; if (d !== 32'h8000_0007) begin errors++; $display("[TB] FAIL irq_mcause: got %h expected %h", d, 32'h8000_0007); end
    csrRead(CSR_MEPC, d);
    checks++; if (d !== 32'h88) begin errors++; $display("[TB] FAIL irq_mepc: got %h expected %h", d, 32'h88); end
    csrRead(CSR_MTVAL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL irq_mtval: got %h expected %h", d, 32'h0); end
    acceptRedirect();
  endtask

  task automatic test_mret();
    csrWrite(CSR_RW, CSR_MEPC, 32'h44);
    csrWrite(CSR_RW, CSR_MSTATUS, 32'h80);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    checks++; if (red_vld !== 1'b1 || red_pc !== 32'h44) begin errors++; $display("[TB] FAIL mret_redir: got vld=%b pc=%h expected 1 00000044", red_vld, red_pc); end
    csrRead(CSR_MSTATUS, d);
    checks++; if (d !== 32'h88) begin errors++; $display("[TB] FAIL mret_mstatus: got %h expected %h", d, 32'h88); end
    acceptRedirect();
  endtask

  task automatic test_simultaneous();
    csrWrite(CSR_RW, CSR_MTVEC, 32'h100);
    csrWrite(CSR_RW, CSR_MIE, 32'h800);
    csrWrite(CSR_RW, CSR_MSTATUS, 32'h8);
    exc_vld = 1'b1; exc_cause = 4'd2; exc_pc = 32'h60; exc_tval = 32'h1;
    irq_mei = 1'b1; mret = 1'b1;
    tick();
    exc_vld = 1'b0; mret = 1'b0;
    checks++; if (red_vld !== 1'b1 || red_pc !== 32'h100) begin errors++; $display("[TB] FAIL sim_redir: got vld=%b pc=%h expected 1 00000100", red_vld, red_pc); end
    csrRead(CSR_MCAUSE, d);
    checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL sim_mcause: got %h expected %h", d, 32'h2); end
    csrRead(CSR_MEPC, d);
    checks++; if (d !== 32'h60) begin errors++; $display("[TB] FAIL sim_mepc: got %h expected %h", d, 32'h60); end
    csrRead(CSR_MSTATUS, d);
    checks++; if (d !== 32'h80) begin errors++; $display("[TB] FAIL sim_mstatus: got %h expected %h", d, 32'h80); end
    acceptRedirect();
    tick();
    checks++; if (red_vld !== 1'b0) begin errors++; $display("[TB] FAIL sim_masked: got %b expected 0", red_vld); end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    checks++; if (red_vld !== 1'b1 || red_pc !== 32'h60) begin errors++; $display("[TB] FAIL sim_mret: got vld=%b pc=%h expected 1 00000060", red_vld, red_pc); end
    acceptRedirect();
    checks++; if (red_vld !== 1'b0) begin errors++; $display("[TB] FAIL sim_mret_release: got %b expected 0", red_vld); end
    nxt_pc = 32'h64;
    tick();
    checks++; if (red_vld !== 1'b1 || red_pc !== 32'h100) begin errors++; $display("[TB] FAIL sim_irq_redir: got vld=%b pc=%h expected 1 00000100", red_vld, red_pc); end
    csrRead(CSR_MCAUSE, d);
    checks++; if (d !== 32'h8000_000B) begin errors++; $display("[TB] FAIL sim_irq_mcause: got %h expected %h", d, 32'h8000_000B); end
    csrRead(CSR_MEPC, d);
    checks++; if (d !== 32'h64) begin errors++; $display("[TB] FAIL sim_irq_mepc: got %h expected %h", d, 32'h64); end
    irq_mei = 1'b0;
    acceptRedirect();
  endtask

  task automatic test_csr_ops();
    csrWrite(CSR_RW, CSR_MIE, 32'h0);
    ctl.op = CSR_SET; ctl.msk = CSR_IMM; ctl.adr = CSR_MIE; ctl.imm = 5'h1F;
    tick();
    ctl.op = CSR_NON; ctl.msk = CSR_REG; ctl.imm = 5'h0;
    csrRead(CSR_MIE, d);
    checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL mie_seti: got %h expected %h", d, 32'h8); end
    csrWrite(CSR_SET, CSR_MIE, 32'hFFFF_FFFF);
    csrRead(CSR_MIE, d);
    checks++; if (d !== 32'h888) begin errors++; $display("[TB] FAIL mie_set: got %h expected %h", d, 32'h888); end
    irq_msi = 1'b1;
    csrWrite(CSR_RW, CSR_MIP, 32'hFFFF_FFFF);
    csrRead(CSR_MIP, d);
    checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL mip_ro: got %h expected %h", d, 32'h8); end
    irq_msi = 1'b0;
    csrWrite(CSR_RW, CSR_MIE, 32'h0);
    csrWrite(CSR_RW, CSR_MTVEC, 32'h303);
    csrRead(CSR_MTVEC, d);
    checks++; if (d !== 32'h300) begin errors++; $display("[TB] FAIL mtvec_mode: got %h expected %h", d, 32'h300); end
    csrWrite(CSR_RW, CSR_MEPC, 32'h47);
    csrRead(CSR_MEPC, d);
    checks++; if (d !== 32'h44) begin errors++; $display("[TB] FAIL mepc_align: got %h expected %h", d, 32'h44); end
    csrWrite(CSR_RW, CSR_MSCRATCH, 32'hA5A5);
    csrWrite(CSR_CLR, CSR_MSCRATCH, 32'hF);
    csrRead(CSR_MSCRATCH, d);
    checks++; if (d !== 32'hA5A0) begin errors++; $display("[TB] FAIL mscratch_clr: got %h expected %h", d, 32'hA5A0); end
    csrWrite(CSR_RW, CSR_MSTATUS, 32'hFFFF_FFFF);
    csrRead(CSR_MSTATUS, d);
    checks++; if (d !== 32'h88) begin errors++; $display("[TB] FAIL mstatus_mask: got %h expected %h", d, 32'h88); end
    csrRead(12'h001, d);
    checks++; if (d !== 32'h0 || hit !== 1'b0) begin errors++; $display("[TB] FAIL miss: got rdt=%h hit=%b expected 0 0", d, hit); end
    csrRead(CSR_MSCRATCH, d);
    checks++; if (hit !== 1'b1) begin errors++; $display("[TB] FAIL hit: got %b expected 1", hit); end
  endtask

  task automatic test_rollover();
    csrWrite(CSR_RW, CSR_MCYCLEH, 32'h5);
    csrWrite(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
    csrRead(CSR_MCYCLE, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mcycle_wr: got %h expected %h", d, 32'hFFFF_FFFF); end
    csrRead(CSR_MCYCLEH, d);
    checks++; if (d !== 32'h5) begin errors++; $display("[TB] FAIL mcycleh_pre: got %h expected %h", d, 32'h5); end
    tick();
    csrRead(CSR_MCYCLE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mcycle_wrap: got %h expected %h", d, 32'h0); end
    csrRead(CSR_MCYCLEH, d);
    checks++; if (d !== 32'h6) begin errors++; $display("[TB] FAIL mcycleh_carry: got %h expected %h", d, 32'h6); end
    csrWrite(CSR_RW, CSR_MINSTRET, 32'hFFFF_FFFF);
    tick();
    csrRead(CSR_MINSTRET, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL minstret_hold: got %h expected %h", d, 32'hFFFF_FFFF); end
    ret = 1'b1;
    tick();
    ret = 1'b0;
    csrRead(CSR_MINSTRET, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL minstret_wrap: got %h expected %h", d, 32'h0); end
    csrRead(CSR_MINSTRETH, d);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL minstreth_carry: got %h expected %h", d, 32'h1); end
  endtask

  initial begin
    rst = 1'b0;
    ctl = '0;
    ctl.op = CSR_NON; ctl.msk = CSR_REG;
    wdt = '0; exc_vld = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret = 1'b0; ret = 1'b0; nxt_pc = '0;
    irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0; red_rdy = 1'b0;
    #1;
    checks++; if (red_vld !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL in_reset: got vld=%b stall=%b expected 0 0", red_vld, stall); end
    test_reset();
    test_exception();
    test_vectored_irq();
    test_mret();
    test_simultaneous();
    test_csr_ops();
    test_rollover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
